// File: rtl/int4_mac_pkg.sv
// Shared widths and state encoding for the INT4 dot-product MAC and its sequencer.
package int4_mac_pkg;

    localparam int unsigned NIB_W       = 4;
    localparam int unsigned VEC_W       = 264;
    localparam int unsigned LANES       = 66;
    localparam int unsigned SCALE_LANES = 2;
    localparam int unsigned DATA_LANES  = LANES - SCALE_LANES - 1;
    localparam int unsigned PROD_W      = 2 * NIB_W;
    localparam int unsigned ACC_W       = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/int4_mac.sv
// Combinational INT4 dot product over the 63 data nibbles, optionally added to a running partial sum.
module int4_mac
    import int4_mac_pkg::*;
(
    input  logic [VEC_W-1:0] a_vec,
    input  logic [VEC_W-1:0] b_vec,
    input  logic             int4_en,
    input  logic [ACC_W-1:0] partial_sum_in,
    output logic [ACC_W-1:0] partial_sum_out
);

    logic [ACC_W-1:0]  sum;
    logic [PROD_W-1:0] prod;

    always_comb begin
        sum  = int4_en ? partial_sum_in : '0;
        prod = '0;
        for (int unsigned i = SCALE_LANES; i < SCALE_LANES + DATA_LANES; i++) begin
            prod = PROD_W'(a_vec[i*NIB_W +: NIB_W]) * PROD_W'(b_vec[i*NIB_W +: NIB_W]);
            sum  = sum + ACC_W'(prod);
        end
    end

    assign partial_sum_out = sum;

    // scale and pad nibbles never enter the product
    logic unused_lanes;
    assign unused_lanes = ^{a_vec[SCALE_LANES*NIB_W-1:0], b_vec[SCALE_LANES*NIB_W-1:0],
                            a_vec[VEC_W-1:(SCALE_LANES+DATA_LANES)*NIB_W],
                            b_vec[VEC_W-1:(SCALE_LANES+DATA_LANES)*NIB_W]};

endmodule

// File: rtl/int4_mac_ctrl.sv
// Job sequencer: streams num_blk operand blocks through int4_mac, accumulates, and hands off the sum.
module int4_mac_ctrl #(
    parameter int unsigned BLK_W = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [BLK_W-1:0]               num_blk,
    input  logic                           abort,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [int4_mac_pkg::VEC_W-1:0] a_vec,
    input  logic [int4_mac_pkg::VEC_W-1:0] b_vec,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_sum,
    output logic [7:0]                     out_scale_a,
    output logic [7:0]                     out_scale_b,
    output logic                           out_ovf,
    output logic                           busy
);
    import int4_mac_pkg::*;

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [BLK_W-1:0] cnt;
    logic [BLK_W-1:0] num_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mac_sum;
    logic [7:0]       scale_a;
    logic [7:0]       scale_b;
    logic             ovf;
    logic             beat;
    logic             first_beat;
    logic             last_beat;

    assign beat       = (state == RUN) && in_valid && !abort;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == num_q - BLK_W'(1));

    // ACC_W must equal the MAC partial-sum width
    int4_mac u_mac (
        .a_vec           (a_vec),
        .b_vec           (b_vec),
        .int4_en         (!first_beat),
        .partial_sum_in  (acc),
        .partial_sum_out (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_blk != '0) ? RUN : DONE;
            RUN:  if (beat && last_beat) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Job datapath: abort wins over beat accept and job launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            num_q   <= '0;
            acc     <= '0;
            scale_a <= '0;
            scale_b <= '0;
            ovf     <= 1'b0;
        end else if (abort) begin
            cnt <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q <= num_blk;
                        cnt   <= '0;
                        if (num_blk == '0) begin
                            acc     <= '0;
                            scale_a <= '0;
                            scale_b <= '0;
                            ovf     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        acc <= mac_sum;
                        cnt <= cnt + BLK_W'(1);
                        if (first_beat) begin
                            scale_a <= a_vec[7:0];
                            scale_b <= b_vec[7:0];
                            ovf     <= 1'b0;
                        end else if (mac_sum < acc) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == RUN) && !abort;
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign out_sum     = acc;
    assign out_scale_a = scale_a;
    assign out_scale_b = scale_b;
    assign out_ovf     = ovf;

endmodule
